// File: rtl/code_lock_pkg.sv
// ============================================================================
// Module   : code_lock_pkg
// Brief    : Shared types, constants and code-digit lookup for code_lock.
// Revision : 1.0
// ============================================================================
`default_nettype none

package code_lock_pkg;

    localparam int NDIG = 4;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    // Digit 0 lives in the most significant pair of the code word.
    function automatic logic [1:0] code_digit(input logic [7:0] code, input logic [1:0] idx);
        logic [1:0] dig;
        case (idx)
            2'd0:    dig = code[7:6];
            2'd1:    dig = code[5:4];
            2'd2:    dig = code[3:2];
            default: dig = code[1:0];
        endcase
        return dig;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pair_eq.sv
// ============================================================================
// Module   : pair_eq
// Brief    : Combinational 2-bit equality, eq = (a==c) && (b==d).
// Revision : 1.0
// ============================================================================
`default_nettype none

module pair_eq (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic eq
);

    assign eq = (a == c) && (b == d);

endmodule

`default_nettype wire

// File: rtl/code_lock.sv
// ============================================================================
// Module   : code_lock
// Brief    : 4-digit sequential code lock with timed open window and lockout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module code_lock
    import code_lock_pkg::*;
#(
    parameter logic [7:0] CODE     = 8'b10_01_11_00,
    parameter int         MAX_FAIL = 3,
    parameter int         OPEN_CYC = 8,
    parameter int         LOCK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] digit,
    input  logic       digit_vld,
    input  logic       clear,
    output logic       open,
    output logic       err,
    output logic       locked,
    output logic [1:0] pos
);

    localparam int TMAX = (OPEN_CYC > LOCK_CYC) ? OPEN_CYC : LOCK_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(MAX_FAIL + 1);

    localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYC);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYC);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
    localparam logic [1:0]    LAST_POS  = 2'(NDIG - 1);

    state_t        state_q, state_d;
    logic [1:0]    pos_q, pos_d;
    logic          mm_q, mm_d;
    logic [FW-1:0] fail_cnt_q, fail_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;

    logic [1:0]    code_dig;
    logic          digit_eq;

    assign code_dig = code_digit(CODE, pos_q);

    pair_eq u_pair_eq (
        .a  (digit[1]),
        .b  (digit[0]),
        .c  (code_dig[1]),
        .d  (code_dig[0]),
        .eq (digit_eq)
    );

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        mm_d       = mm_q;
        fail_cnt_d = fail_cnt_q;
        timer_d    = timer_q;
        err_d      = 1'b0;

        case (state_q)
            ENTRY: begin
                if (clear) begin
                    pos_d = 2'd0;
                    mm_d  = 1'b0;
                end else if (digit_vld) begin
                    if (pos_q == LAST_POS) begin
                        pos_d = 2'd0;
                        mm_d  = 1'b0;
                        if (!mm_q && digit_eq) begin
                            state_d    = OPEN;
                            timer_d    = OPEN_LOAD;
                            fail_cnt_d = '0;
                        end else begin
                            err_d = 1'b1;
                            // Counter saturates at MAX_FAIL while locked out.
                            fail_cnt_d = fail_cnt_q + 1'b1;
                            if (fail_cnt_q == FAIL_LAST) begin
                                state_d = LOCKOUT;
                                timer_d = LOCK_LOAD;
                            end
                        end
                    end else begin
                        pos_d = pos_q + 2'd1;
                        mm_d  = mm_q | ~digit_eq;
                    end
                end
            end
            OPEN: begin
                timer_d = timer_q - 1'b1;
                if (timer_q == TIMER_ONE) begin
                    state_d = ENTRY;
                end
            end
            LOCKOUT: begin
                timer_d = timer_q - 1'b1;
                if (timer_q == TIMER_ONE) begin
                    state_d    = ENTRY;
                    fail_cnt_d = '0;
                end
            end
            default: begin
                state_d = ENTRY;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ENTRY;
            pos_q      <= 2'd0;
            mm_q       <= 1'b0;
            fail_cnt_q <= '0;
            timer_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            mm_q       <= mm_d;
            fail_cnt_q <= fail_cnt_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
        end
    end

    assign open   = (state_q == OPEN);
    assign locked = (state_q == LOCKOUT);
    assign err    = err_q;
    assign pos    = pos_q;

endmodule

`default_nettype wire

// File: tb/tb_code_lock.sv
// ============================================================================
// Module   : tb_code_lock
// Brief    : Self-checking bench for code_lock against an attempt-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_code_lock;

    localparam logic [7:0] CODE     = 8'b10_01_11_00;
    localparam int         MAX_FAIL = 3;
    localparam int         OPEN_CYC = 8;
    localparam int         LOCK_CYC = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] digit;
    logic       digit_vld;
    logic       clear;
    logic       open;
    logic       err;
    logic       locked;
    logic [1:0] pos;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: digits typed so far, remaining window lengths, fail tally.
    int entered[$];
    int m_open_left = 0;
    int m_lock_left = 0;
    int m_fails     = 0;
    bit m_err       = 1'b0;

    code_lock #(
        .CODE     (CODE),
        .MAX_FAIL (MAX_FAIL),
        .OPEN_CYC (OPEN_CYC),
        .LOCK_CYC (LOCK_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digit     (digit),
        .digit_vld (digit_vld),
        .clear     (clear),
        .open      (open),
        .err       (err),
        .locked    (locked),
        .pos       (pos)
    );

    always #5 clk = ~clk;

    function automatic int code_dig(int i);
        return (int'(CODE) >> (2 * (3 - i))) & 3;
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("open",   {7'd0, open},   {7'd0, m_open_left > 0});
        chk("locked", {7'd0, locked}, {7'd0, m_lock_left > 0});
        chk("err",    {7'd0, err},    {7'd0, m_err});
        chk("pos",    {6'd0, pos},    8'(entered.size()));
    endtask

    task automatic model_reset();
        entered.delete();
        m_open_left = 0;
        m_lock_left = 0;
        m_fails     = 0;
        m_err       = 1'b0;
    endtask

    task automatic model_edge(int d, bit v, bit c);
        bit ok;
        m_err = 1'b0;
        if (m_open_left > 0) begin
            m_open_left--;
        end else if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fails = 0;
        end else if (c) begin
            entered.delete();
        end else if (v) begin
            entered.push_back(d);
            if (entered.size() == 4) begin
                ok = 1'b1;
                for (int i = 0; i < 4; i++)
                    if (entered[i] != code_dig(i)) ok = 1'b0;
                entered.delete();
                if (ok) begin
                    m_open_left = OPEN_CYC;
                    m_fails     = 0;
                end else begin
                    m_err = 1'b1;
                    m_fails++;
                    if (m_fails == MAX_FAIL) m_lock_left = LOCK_CYC;
                end
            end
        end
    endtask

    task automatic cycle(int d, bit v, bit c);
        digit     = 2'(d);
        digit_vld = v;
        clear     = c;
        @(posedge clk);
        model_edge(d, v, c);
        #1;
        check_all();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(0, 1'b0, 1'b0);
    endtask

    task automatic enter4(int a, int b, int c, int d);
        cycle(a, 1'b1, 1'b0);
        cycle(b, 1'b1, 1'b0);
        cycle(c, 1'b1, 1'b0);
        cycle(d, 1'b1, 1'b0);
    endtask

    // Pulse reset between clock edges and confirm outputs drop before any edge.
    task automatic async_rst();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int d;
        bit v;
        bit c;

        rst       = 1'b1;
        digit     = 2'd0;
        digit_vld = 1'b0;
        clear     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Correct code, back-to-back strobes
        enter4(2, 1, 3, 0);
        idle(10);

        // Wrong then correct
        enter4(2, 1, 3, 1);
        idle(2);
        enter4(2, 1, 3, 0);
        idle(10);

        // Three failures into lockout; strobes during lockout ignored
        enter4(0, 0, 0, 0);
        idle(1);
        enter4(0, 0, 0, 0);
        idle(1);
        enter4(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(3, 1'b1, 1'b0);
        idle(14);
        enter4(2, 1, 3, 0);
        idle(10);

        // Clear wins over a simultaneous strobe
        cycle(2, 1'b1, 1'b0);
        cycle(1, 1'b1, 1'b0);
        cycle(3, 1'b1, 1'b1);
        idle(1);
        enter4(2, 1, 3, 0);
        idle(10);

        // Async reset in open window cycle 4
        enter4(2, 1, 3, 0);
        idle(3);
        async_rst();
        idle(2);

        // Async reset in lockout cycle 5, then a wrong attempt must not lock
        enter4(0, 0, 0, 0);
        enter4(0, 0, 0, 0);
        enter4(0, 0, 0, 0);
        idle(4);
        async_rst();
        idle(1);
        enter4(0, 0, 0, 0);
        idle(2);

        // Strobes during open window ignored
        enter4(2, 1, 3, 0);
        for (int i = 0; i < 4; i++) cycle(3, 1'b1, 1'b0);
        idle(8);

        // Random traffic biased toward the correct code
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 4) == 0 || entered.size() > 3)
                d = int'($urandom_range(0, 3));
            else
                d = code_dig(entered.size());
            cycle(d, v, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/code_lock.md
# code_lock

Sequential digit-entry lock that consumes 2-bit digits one per strobe and compares each against a stored 4-digit code using a 2-bit pair-equality comparator. It sits downstream of the keypad encoder and upstream of the actuator/indicator stage. It drives a timed `open` window, a per-attempt error pulse, and a timed lockout after repeated failures.

## Interface
- `CODE`, 8'b10_01_11_00, stored code; digit 0 in [7:6], digit 3 in [1:0]
- `MAX_FAIL`, 3, consecutive failed attempts that trigger lockout (≥1)
- `OPEN_CYC`, 8, cycles `open` stays high (≥1)
- `LOCK_CYC`, 16, cycles `locked` stays high (≥1)
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `digit`  in  2  entered digit, sampled when `digit_vld`=1
- `digit_vld`  in  1  one-cycle strobe, one digit per high cycle
- `clear`  in  1  abandon the current entry
- `open`  out  1  code accepted; high for exactly OPEN_CYC cycles
- `err`  out  1  one-cycle pulse on a wrong 4-digit attempt
- `locked`  out  1  lockout active; high for exactly LOCK_CYC cycles
- `pos`  out  2  digits accepted so far in the current attempt (0–3)

## Operation
- States: ENTRY, OPEN, LOCKOUT. Reset → ENTRY with pos=0, mismatch flag mm=0, fail_cnt=0, timer=0.
- Reset values: open=0, err=0, locked=0, pos=0.
- ENTRY, `digit_vld`=1, `clear`=0:
  - Compare `digit` against the CODE digit selected by pos.
  - Any mismatch sets mm; mm is sticky for the rest of the attempt.
  - pos increments on every accepted digit. Wrong digits do not abort early; all 4 digits are always taken.
- 4th digit (pos=3 and accepted), with match = !mm && current digit equal:
  - Match: → OPEN, timer loads OPEN_CYC, fail_cnt←0.
  - Mismatch, fail_cnt+1 < MAX_FAIL: err pulses, fail_cnt increments, stay in ENTRY.
  - Mismatch, fail_cnt+1 = MAX_FAIL: err pulses, → LOCKOUT, timer loads LOCK_CYC.
  - In every case pos←0 and mm←0.
- `clear` in ENTRY: pos←0, mm←0; fail_cnt is unchanged. If `clear` and `digit_vld` arrive together, clear wins and the digit is discarded.
- OPEN: `open`=1. Timer decrements each cycle; at 1 → ENTRY. Digits and `clear` are ignored.
- LOCKOUT: `locked`=1. Timer decrements each cycle; at 1 → ENTRY with fail_cnt←0. Digits and `clear` are ignored.
- Width rules:
  - timer is $clog2(max(OPEN_CYC, LOCK_CYC)+1) bits.
  - fail_cnt is $clog2(MAX_FAIL+1) bits and never exceeds MAX_FAIL.
  - pos wraps 3→0 only via attempt completion.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `pos` updates the cycle after the accepted strobe.
- Final-digit edge at cycle t:
  - Correct code: `open` is high in cycles t+1 … t+OPEN_CYC.
  - Wrong code: `err` is high in cycle t+1 only.
  - Wrong code reaching MAX_FAIL: `err` and `locked` both rise at t+1; `locked` stays high through t+LOCK_CYC.
- A digit strobe in the first cycle after OPEN/LOCKOUT ends is accepted as digit 0.
- Back-to-back strobes on consecutive cycles are all accepted; no idle cycle is required.
- `rst` asserted mid-attempt, mid-OPEN or mid-LOCKOUT immediately forces all reset values, independent of `clk`.

## Structure
- Package `code_lock_pkg`:
  - state enum {ENTRY, OPEN, LOCKOUT}
  - constant NDIG=4
  - function returning CODE digit by index
- Sub-module `pair_eq`: combinational 2-bit equality, eq = (a==c)&&(b==d). It is the same function as the team's existing 2-bit equality detector and is instantiated once, comparing `digit` with the selected code digit.
- Remaining RTL: FSM, pos/mm registers, fail counter, shared down-timer.

## Test plan
- Reset, then digits 2,1,3,0 on consecutive cycles → pos steps 1,2,3,0; `open`=1 for exactly 8 cycles starting one cycle after digit 0; err=0 and locked=0 throughout.
- Digits 2,1,3,1 → single err pulse at t+1; open stays 0; fail_cnt=1; then 2,1,3,0 → open window; fail_cnt cleared.
- Three wrong attempts (0,0,0,0 ×3) → err pulses after the 1st and 2nd; on the 3rd, err and locked rise together; locked lasts 16 cycles; digits strobed during lockout leave pos=0; afterwards 2,1,3,0 opens.
- Digits 2,1, then `clear` together with `digit_vld` (digit=3) → pos=0, no err; then 2,1,3,0 opens (the cleared partial entry does not count as a failure).
- `rst` pulsed asynchronously (between clock edges) during cycle 4 of the open window and during cycle 5 of lockout → open/locked drop immediately; pos=0; fail_cnt=0 (next wrong attempt gives err without lockout).
- Digits strobed during OPEN (3,3,3,3) → ignored; pos stays 0; no err after the window closes.
